// File: rtl/overlap_recombine_pipe_pkg.sv
// Shared GF(2) multiplier definitions: middle-term mode encoding and
// product-width helper used by the recombination pipeline.
package overlap_recombine_pipe_pkg;

  localparam logic MODE_SCHOOL = 1'b0;
  localparam logic MODE_KARA   = 1'b1;

  // Width of the carry-free product of two n-bit operands.
  function automatic int prod_width(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/overlap_recombine_comb.sv
// Combinational overlap-add of the four half-products into the full
// GF(2) product. Even half-products land on even bit positions, the
// middle term fills the odd positions.
module overlap_recombine_comb
  import overlap_recombine_pipe_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         mode,
  input  logic [N-2:0] pp_ee,
  input  logic [N-2:0] pp_x1,
  input  logic [N-2:0] pp_x2,
  input  logic [N-2:0] pp_oo,
  output logic [2*N-2:0] prod
);

  logic [N-2:0] mid;

  // Karatsuba recovers the middle term by cancelling P1 and P4 out of the
  // cross product; schoolbook just sums the two cross terms.
  always_comb begin
    mid = (mode == MODE_KARA) ? (pp_x1 ^ pp_ee ^ pp_oo) : (pp_x1 ^ pp_x2);
    prod = '0;
    prod[0] = pp_ee[0];
    for (int k = 1; k <= N - 2; k++) begin
      prod[2*k] = pp_ee[k] ^ pp_oo[k-1];
    end
    prod[2*N-2] = pp_oo[N-2];
    for (int k = 0; k <= N - 2; k++) begin
      prod[2*k+1] = mid[k];
    end
  end

endmodule

// File: rtl/overlap_recombine_pipe.sv
// Two-stage valid/ready pipeline around the half-product recombiner.
// S1 captures operands, mode and tag; S2 holds the recombined product.
// Stages advance only when the stage downstream can take data, so a
// stalled output freezes both stages without loss or duplication.
module overlap_recombine_pipe
  import overlap_recombine_pipe_pkg::*;
#(
  parameter int N    = 4,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_mode,
  input  logic [TAGW-1:0] in_tag,
  input  logic [N-2:0]    pp_ee,
  input  logic [N-2:0]    pp_x1,
  input  logic [N-2:0]    pp_x2,
  input  logic [N-2:0]    pp_oo,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TAGW-1:0] out_tag,
  output logic [2*N-2:0]  out_prod
);

  localparam int PW = prod_width(N);

  logic            s1_valid;
  logic            s1_mode;
  logic [TAGW-1:0] s1_tag;
  logic [N-2:0]    s1_ee;
  logic [N-2:0]    s1_x1;
  logic [N-2:0]    s1_x2;
  logic [N-2:0]    s1_oo;

  logic            s2_valid;
  logic [TAGW-1:0] s2_tag;
  logic [PW-1:0]   s2_prod;

  logic [PW-1:0]   comb_prod;
  logic            s2_adv;
  logic            s1_adv;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s1_adv;

  overlap_recombine_comb #(.N(N)) u_comb (
    .mode  (s1_mode),
    .pp_ee (s1_ee),
    .pp_x1 (s1_x1),
    .pp_x2 (s1_x2),
    .pp_oo (s1_oo),
    .prod  (comb_prod)
  );

  // S1: capture an accepted transaction; payload only moves on a real accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_SCHOOL;
      s1_tag   <= '0;
      s1_ee    <= '0;
      s1_x1    <= '0;
      s1_x2    <= '0;
      s1_oo    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= in_mode;
        s1_tag  <= in_tag;
        s1_ee   <= pp_ee;
        s1_x1   <= pp_x1;
        s1_x2   <= pp_x2;
        s1_oo   <= pp_oo;
      end
    end
  end

  // S2: register the recombined product whenever the output slot frees up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_tag   <= '0;
      s2_prod  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_tag  <= s1_tag;
        s2_prod <= comb_prod;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_tag   = s2_tag;
  assign out_prod  = s2_prod;

endmodule
